// File: rtl/eth_tx_scheduler.sv
// ---------------------------------------------------------------------------
// eth_tx_scheduler
//
// Shares one GMII transmit path between up to eight frame sources. Port 0
// (ARP) has fixed priority; ports 1..NUM_PORTS-1 are served round-robin.
// A grant lasts until the granted port signals end-of-frame, or until the
// watchdog expires. An inter-frame gap is always enforced before the next
// grant. The selected byte stream is registered toward the RGMII converter.
//
// Ports:
//   clk          GMII TX clock (125 MHz)
//   rstn         synchronous active-low reset
//   req          per-port transmit request (level)
//   done         per-port end-of-frame pulse
//   sel          one-hot grant, zero when nothing is granted
//   tx_en_in     per-port GMII enable
//   txd_in       per-port GMII data, port k at [8k+7:8k]
//   gmii_tx_en   registered, muxed GMII enable
//   gmii_txd     registered, muxed GMII data
//   busy         high while a grant or inter-frame gap is in progress
//   timeout_err  one-cycle pulse when the watchdog forces a release
//   err_port     index of the last port that timed out
// ---------------------------------------------------------------------------
module eth_tx_scheduler #(
    parameter int NUM_PORTS      = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_PORTS-1:0]   req,
    input  logic [NUM_PORTS-1:0]   done,
    output logic [NUM_PORTS-1:0]   sel,
    input  logic [NUM_PORTS-1:0]   tx_en_in,
    input  logic [8*NUM_PORTS-1:0] txd_in,
    output logic                   gmii_tx_en,
    output logic [7:0]             gmii_txd,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [2:0]             err_port
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int IFG_W = $clog2(IFG_CYCLES) + 1;

    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IFG_W-1:0] IFG_LIMIT = IFG_W'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        IFG
    } state_t;

    state_t               state;
    logic [2:0]           rr_ptr;
    logic [2:0]           grant_idx;
    logic [WD_W-1:0]      wdog;
    logic [IFG_W-1:0]     ifg_cnt;

    logic [2:0]           winner;
    logic [NUM_PORTS-1:0] winner_onehot;
    logic                 found;
    logic                 mux_en;
    logic [7:0]           mux_txd;

    // Winner selection. Port 0 always wins when requesting; otherwise the
    // round-robin search starts just after rr_ptr and wraps from the last
    // port back to port 1 (port 0 is never part of the rotation).
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        if (!req[0]) begin
            for (int off = 0; off < NUM_PORTS - 1; off++) begin
                for (int p = 1; p < NUM_PORTS; p++) begin
                    if (!found && req[p] &&
                        (p == ((int'(rr_ptr) + off) % (NUM_PORTS - 1)) + 1)) begin
                        winner = 3'(p);
                        found  = 1'b1;
                    end
                end
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            winner_onehot[p] = (winner == 3'(p));
        end
    end

    // Byte-stream mux driven by the current grant; sel is one-hot or zero,
    // so at most one port contributes.
    always_comb begin
        mux_en  = 1'b0;
        mux_txd = 8'h00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel[p]) begin
                mux_en  = tx_en_in[p];
                mux_txd = txd_in[8*p +: 8];
            end
        end
    end

    // Scheduler state machine with registered outputs. The done pulse of the
    // granted port takes precedence over a watchdog expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            sel         <= '0;
            gmii_tx_en  <= 1'b0;
            gmii_txd    <= 8'h00;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err_port    <= 3'd0;
            rr_ptr      <= 3'(NUM_PORTS - 1);
            grant_idx   <= 3'd0;
            wdog        <= '0;
            ifg_cnt     <= '0;
        end else begin
            timeout_err <= 1'b0;
            gmii_tx_en  <= mux_en;
            gmii_txd    <= mux_txd;

            case (state)
                IDLE: begin
                    if (|req) begin
                        sel       <= winner_onehot;
                        grant_idx <= winner;
                        wdog      <= '0;
                        busy      <= 1'b1;
                        state     <= GRANT;
                        if (winner != 3'd0) begin
                            rr_ptr <= winner;
                        end
                    end
                end

                GRANT: begin
                    if (|(done & sel)) begin
                        sel     <= '0;
                        ifg_cnt <= '0;
                        state   <= IFG;
                    end else if (wdog == WD_LIMIT) begin
                        sel         <= '0;
                        ifg_cnt     <= '0;
                        timeout_err <= 1'b1;
                        err_port    <= grant_idx;
                        state       <= IFG;
                    end else if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                end

                IFG: begin
                    if (ifg_cnt == IFG_LIMIT) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (ifg_cnt != '1) begin
                        ifg_cnt <= ifg_cnt + 1'b1;
                    end
                end

                default: begin
                    sel   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
